// File: rtl/udm_arb_pkg.sv
// Shared types and constants for the udm two-master bus arbiter.
// Used by udm_bus_arb and udm_arb_idfifo.
package udm_arb_pkg;

  localparam int N_MASTERS = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;

  typedef logic mid_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Grant choice for the current request vector; on a tie round-robin favours the master not granted last.
  function automatic mid_t arb_pick(
    input logic [N_MASTERS-1:0] req,
    input mid_t                 last,
    input logic                 rr_en
  );
    mid_t pick;
    pick = 1'b0;
    if (req[0] && req[1]) begin
      pick = rr_en ? ~last : 1'b0;
    end else if (req[1]) begin
      pick = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/udm_arb_idfifo.sv
// Small FIFO of master ids for outstanding reads; head is visible combinationally.
// Pop while empty is ignored; push while full is accepted only together with a pop.
module udm_arb_idfifo
  import udm_arb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = mid_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == FULL_CNT);
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign dout_o  = r_mem[r_rptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/udm_bus_arb.sv
// Two-master arbiter (m0 = udm debug, m1 = CPU data) onto one slave bus, with read-response routing.
// Define UDM_ARB_RR_EN for round-robin tie breaking; otherwise master 0 has fixed priority.
module udm_bus_arb
  import udm_arb_pkg::*;
#(
  parameter int PEND_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_MASTERS-1:0]        m_req_i,
  output logic [N_MASTERS-1:0]        m_ack_o,
  input  logic [N_MASTERS-1:0]        m_we_i,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr_bi,
  input  logic [N_MASTERS*BE_W-1:0]   m_be_bi,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata_bi,
  output logic [N_MASTERS-1:0]        m_resp_o,
  output logic [DATA_W-1:0]           m_rdata_bo,
  output logic                        s_req_o,
  input  logic                        s_ack_i,
  output logic                        s_we_o,
  output logic [ADDR_W-1:0]           s_addr_bo,
  output logic [BE_W-1:0]             s_be_bo,
  output logic [DATA_W-1:0]           s_wdata_bo,
  input  logic                        s_resp_i,
  input  logic [DATA_W-1:0]           s_rdata_bi,
  output logic                        err_unexp_resp_o
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  mid_t       r_gnt;
  mid_t       w_gnt_next;
  mid_t       w_pick;
  mid_t       w_head;
  logic       r_err;
  logic       w_s_req;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_rd_block;

  logic [ADDR_W-1:0] w_addr  [N_MASTERS];
  logic [BE_W-1:0]   w_be    [N_MASTERS];
  logic [DATA_W-1:0] w_wdata [N_MASTERS];

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
    assign w_addr[gi]   = m_addr_bi[gi*ADDR_W +: ADDR_W];
    assign w_be[gi]     = m_be_bi[gi*BE_W +: BE_W];
    assign w_wdata[gi]  = m_wdata_bi[gi*DATA_W +: DATA_W];
    assign m_ack_o[gi]  = w_accept & (r_gnt == mid_t'(gi));
    assign m_resp_o[gi] = w_pop & (w_head == mid_t'(gi));
  end

`ifdef UDM_ARB_RR_EN
  mid_t r_last;

  // Reset value 1 so that master 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= r_gnt;
    end
  end

  assign w_pick = arb_pick(m_req_i, r_last, 1'b1);
`else
  assign w_pick = arb_pick(m_req_i, 1'b0, 1'b0);
`endif

  // A response popping in this cycle frees the slot a blocked read needs.
  assign w_pop      = s_resp_i & ~w_empty;
  assign w_rd_block = ~m_we_i[r_gnt] & w_full & ~w_pop;
  assign w_push     = w_accept & ~m_we_i[r_gnt];

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_s_req      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (|m_req_i) begin
          w_gnt_next   = w_pick;
          w_state_next = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        w_s_req  = m_req_i[r_gnt] & ~w_rd_block;
        w_accept = w_s_req & s_ack_i;
        if (w_accept || !m_req_i[r_gnt]) begin
          w_state_next = ARB_IDLE;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      r_gnt   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_err   <= r_err | (s_resp_i & w_empty);
    end
  end

  udm_arb_idfifo #(
    .DEPTH (PEND_DEPTH),
    .T     (mid_t)
  ) u_idfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .din_i   (r_gnt),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Payload is held at zero whenever no request is being presented to the slave.
  assign s_req_o          = w_s_req;
  assign s_we_o           = w_s_req & m_we_i[r_gnt];
  assign s_addr_bo        = w_s_req ? w_addr[r_gnt]  : '0;
  assign s_be_bo          = w_s_req ? w_be[r_gnt]    : '0;
  assign s_wdata_bo       = w_s_req ? w_wdata[r_gnt] : '0;
  assign m_rdata_bo       = w_pop ? s_rdata_bi : '0;
  assign err_unexp_resp_o = r_err;

endmodule

// File: tb/tb_udm_bus_arb.sv
// Directed testbench for udm_bus_arb with ack and read-response scoreboards.
// Expected grant order follows UDM_ARB_RR_EN when it is defined.
module tb_udm_bus_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  m_req_i = '0;
  logic [1:0]  m_ack_o;
  logic [1:0]  m_we_i = '0;
  logic [63:0] m_addr_bi = '0;
  logic [7:0]  m_be_bi = '0;
  logic [63:0] m_wdata_bi = '0;
  logic [1:0]  m_resp_o;
  logic [31:0] m_rdata_bo;
  logic        s_req_o;
  logic        s_ack_i = 1'b1;
  logic        s_we_o;
  logic [31:0] s_addr_bo;
  logic [3:0]  s_be_bo;
  logic [31:0] s_wdata_bo;
  logic        s_resp_i = 1'b0;
  logic [31:0] s_rdata_bi = '0;
  logic        err_unexp_resp_o;

  int n_tests = 0;
  int n_fail  = 0;
  int q_ack[$];
  int q_rd[$];

  always #5 clk_i = ~clk_i;

  udm_bus_arb #(.PEND_DEPTH(4)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .m_req_i          (m_req_i),
    .m_ack_o          (m_ack_o),
    .m_we_i           (m_we_i),
    .m_addr_bi        (m_addr_bi),
    .m_be_bi          (m_be_bi),
    .m_wdata_bi       (m_wdata_bi),
    .m_resp_o         (m_resp_o),
    .m_rdata_bo       (m_rdata_bo),
    .s_req_o          (s_req_o),
    .s_ack_i          (s_ack_i),
    .s_we_o           (s_we_o),
    .s_addr_bo        (s_addr_bo),
    .s_be_bo          (s_be_bo),
    .s_wdata_bo       (s_wdata_bo),
    .s_resp_i         (s_resp_i),
    .s_rdata_bi       (s_rdata_bi),
    .err_unexp_resp_o (err_unexp_resp_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request from master m and waits (bounded) for its ack; called at posedge+1.
  task automatic do_req(input int m, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    int lat;
    int exp_m;
    m_req_i    = 2'b00;
    m_req_i[m] = 1'b1;
    m_we_i[m]  = we;
    m_addr_bi[m*32 +: 32]  = addr;
    m_be_bi[m*4 +: 4]      = be;
    m_wdata_bi[m*32 +: 32] = wd;
    q_ack.push_back(m);
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (c == 0) chk("idle_no_fwd", {31'd0, s_req_o, s_addr_bo}, 64'd0);
      if (m_ack_o != 2'b00) begin
        lat = c;
        break;
      end
      @(posedge clk_i); #1;
    end
    exp_m = q_ack.pop_front();
    chk("ack_grant", {62'd0, m_ack_o}, 64'd1 << exp_m);
    chk("ack_latency", 64'(lat), 64'd1);
    if (lat >= 0) begin
      chk("s_we", {63'd0, s_we_o}, {63'd0, we});
      chk("s_addr", {32'd0, s_addr_bo}, {32'd0, addr});
      chk("s_be", {60'd0, s_be_bo}, {60'd0, be});
      chk("s_wdata", {32'd0, s_wdata_bo}, {32'd0, wd});
      if (!we) q_rd.push_back(m);
    end
    $display("[TB] req m%0d we=%0d addr=%08h lat=%0d ack=%b", m, we, addr, lat, m_ack_o);
    @(posedge clk_i); #1;
    m_req_i = 2'b00;
  endtask

  // Drives one slave response pulse and checks routing against the read scoreboard.
  task automatic do_resp(input logic [31:0] data);
    logic [63:0] exp_resp;
    logic [63:0] exp_data;
    int          mid;
    s_resp_i   = 1'b1;
    s_rdata_bi = data;
    @(negedge clk_i);
    if (q_rd.size() == 0) begin
      exp_resp = 64'd0;
      exp_data = 64'd0;
    end else begin
      mid      = q_rd.pop_front();
      exp_resp = 64'd1 << mid;
      exp_data = {32'd0, data};
    end
    chk("resp_route", {62'd0, m_resp_o}, exp_resp);
    chk("resp_data", {32'd0, m_rdata_bo}, exp_data);
    $display("[TB] resp data=%08h m_resp=%b rdata=%08h", data, m_resp_o, m_rdata_bo);
    @(posedge clk_i); #1;
    s_resp_i   = 1'b0;
    s_rdata_bi = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_seen;
    int e;

    // Reset state
    #3;
    chk("rst_outs", {m_ack_o, m_resp_o, s_req_o, s_we_o, s_be_bo, err_unexp_resp_o}, 64'd0);
    chk("rst_data", {s_addr_bo, m_rdata_bo}, 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Both masters request continuously (writes): tie handling
    m_we_i     = 2'b11;
    m_addr_bi  = {32'h0000_2000, 32'h0000_1000};
    m_be_bi    = 8'hFF;
    m_wdata_bi = {32'h2222_2222, 32'h1111_1111};
    m_req_i    = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef UDM_ARB_RR_EN
      q_ack.push_back(i % 2);
`else
      q_ack.push_back(0);
`endif
    end
    n_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (m_ack_o != 2'b00) begin
        e = (q_ack.size() > 0) ? q_ack.pop_front() : 0;
        chk("tie_grant", {62'd0, m_ack_o}, 64'd1 << e);
        $display("[TB] tie cycle %0d ack=%b", c, m_ack_o);
        n_seen++;
      end
      @(posedge clk_i); #1;
    end
    chk("tie_count", 64'(n_seen), 64'd4);
    q_ack.delete();
    m_req_i = 2'b00;
    m_we_i  = 2'b00;
    @(posedge clk_i); #1;

    // Single read from m0
    do_req(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    do_resp(32'hDEAD_BEEF);

    // Fill the ID FIFO with m1 reads, then a 5th blocked until a pop
    for (int i = 0; i < 4; i++) do_req(1, 1'b0, 32'h100 + 32'(i * 4), 4'h3, 32'h0);
    m_req_i = 2'b10;
    m_we_i[1] = 1'b0;
    m_addr_bi[63:32] = 32'h0000_0150;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("full_block_req", {63'd0, s_req_o}, 64'd0);
    chk("full_block_ack", {62'd0, m_ack_o}, 64'd0);
    chk("full_block_payload", {32'd0, s_addr_bo}, 64'd0);
    @(posedge clk_i); #1;
    s_resp_i   = 1'b1;
    s_rdata_bi = 32'h0000_0111;
    @(negedge clk_i);
    chk("full_pop_req", {63'd0, s_req_o}, 64'd1);
    chk("full_pop_ack", {62'd0, m_ack_o}, 64'd2);
    e = q_rd.pop_front();
    chk("full_pop_resp", {62'd0, m_resp_o}, 64'd1 << e);
    chk("full_pop_rdata", {32'd0, m_rdata_bo}, 64'h111);
    q_rd.push_back(1);
    $display("[TB] full-fifo push+pop ack=%b resp=%b", m_ack_o, m_resp_o);
    @(posedge clk_i); #1;
    s_resp_i   = 1'b0;
    s_rdata_bi = '0;
    m_req_i    = 2'b00;
    for (int i = 0; i < 4; i++) do_resp(32'h200 + 32'(i));

    // Interleaved reads, in-order responses
    do_req(0, 1'b0, 32'h0000_0300, 4'hF, 32'h0);
    do_req(1, 1'b0, 32'h0000_0304, 4'hF, 32'h0);
    do_req(0, 1'b0, 32'h0000_0308, 4'hF, 32'h0);
    do_resp(32'h0000_000A);
    do_resp(32'h0000_000B);
    do_resp(32'h0000_000C);

    // Unexpected response with empty FIFO
    chk("err_clear_before", {63'd0, err_unexp_resp_o}, 64'd0);
    do_resp(32'h0000_0055);
    @(negedge clk_i);
    chk("err_set", {63'd0, err_unexp_resp_o}, 64'd1);
    repeat (3) @(posedge clk_i);
    #1;
    chk("err_held", {63'd0, err_unexp_resp_o}, 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("err_rst", {63'd0, err_unexp_resp_o}, 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reset while in LOCK with two reads pending
    do_req(0, 1'b0, 32'h0000_0400, 4'hF, 32'h0);
    do_req(1, 1'b0, 32'h0000_0404, 4'hF, 32'h0);
    s_ack_i = 1'b0;
    m_req_i = 2'b01;
    m_we_i[0] = 1'b0;
    m_addr_bi[31:0] = 32'h0000_0408;
    m_wdata_bi[31:0] = 32'hCAFE_F00D;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("lock_req", {63'd0, s_req_o}, 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("lockrst_outs", {m_ack_o, m_resp_o, s_req_o, s_we_o, s_be_bo, err_unexp_resp_o}, 64'd0);
    chk("lockrst_data", {s_addr_bo, s_wdata_bo}, 64'd0);
    m_req_i = 2'b00;
    s_ack_i = 1'b1;
    q_rd.delete();
    q_ack.delete();
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    do_req(0, 1'b1, 32'h0000_0080, 4'hF, 32'h1234_5678);
    do_resp(32'h0000_0099);
    @(negedge clk_i);
    chk("post_rst_fifo_empty", {63'd0, err_unexp_resp_o}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
